// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives operands and accepts results; the slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: two half-adder cells plus a carry flop retire one operand
// bit per cycle, LSB first, and the result is offered over valid/ready.
module ha_cell (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic p, g1, s, g2;

  ha_cell u_ha1 (.a_i(shift_a_q[0]), .b_i(shift_b_q[0]), .s_o(p), .c_o(g1));
  ha_cell u_ha2 (.a_i(p),            .b_i(carry_q),      .s_o(s), .c_o(g2));

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          shift_a_d = bus.a;
          shift_b_d = bus.b;
          carry_d   = bus.cin;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        carry_d   = g1 | g2;
        // cout tracks the running carry so it is final the moment DONE is entered,
        // while staying untouched by the carry-in load at the next handshake.
        cout_d    = g1 | g2;
        sum_d     = {s, sum_q[WIDTH-1:1]};
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_a_q <= '0;
      shift_b_q <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of the bit-serial adder at WIDTH 8, 2 and 32.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(2))  bus2 ();
  serial_adder_if #(.WIDTH(32)) bus32 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set on bus8; returns #1 after the accepting edge, then scrambles inputs.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t = 0;
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.in_valid = 1'b1;
    while (!bus8.in_ready && t < 200) begin tick(); t++; end
    n_checks++;
    if (!bus8.in_ready) begin
      n_fail++;
      $display("FAIL send8_timeout in_ready=%b required 1", bus8.in_ready);
    end
    tick();
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
  endtask

  task automatic collect8(input bit stall, output logic [7:0] s, output logic c);
    int t = 0;
    bit done = 0;
    s = 'x; c = 'x;
    while (!done && t < 400) begin
      bus8.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus8.out_valid && bus8.out_ready) begin
        s = bus8.sum; c = bus8.cout; done = 1;
      end
      tick(); t++;
    end
    bus8.out_ready = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL collect8_timeout out_valid=%b required 1", bus8.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_basic_latency();
    int early = 0;
    send8(8'h35, 8'h4A, 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (bus8.out_valid) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL latency_early out_valid_cycles=%0d required 0", early);
    end
    tick();
    n_checks++;
    if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h7F || bus8.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_35_4a out_valid=%b sum=%h cout=%b required 1 7f 0", bus8.out_valid, bus8.sum, bus8.cout);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.sum !== 8'h7F) begin
      n_fail++;
      $display("FAIL basic_release out_valid=%b in_ready=%b sum=%h required 0 1 7f",
               bus8.out_valid, bus8.in_ready, bus8.sum);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] s; logic c;
    send8(8'hFF, 8'hFF, 1'b1);
    collect8(0, s, c);
    n_checks++;
    if (s !== 8'hFF || c !== 1'b1) begin
      n_fail++;
      $display("FAIL all_ones sum=%h cout=%b required ff 1", s, c);
    end
    send8(8'h80, 8'h80, 1'b0);
    collect8(0, s, c);
    n_checks++;
    if (s !== 8'h00 || c !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_carry sum=%h cout=%b required 00 1", s, c);
    end
    n_checks++;
    if (bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold sum=%h cout=%b required 00 1", bus8.sum, bus8.cout);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int t = 0;
    logic [7:0] s; logic c;
    bus8.out_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0);
    while (!bus8.out_valid && t < 50) begin tick(); t++; end
    bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b1; bus8.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h46 || bus8.cout !== 1'b0 || bus8.in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold unstable_cycles=%0d required 0 (sum=%h cout=%b)", bad, bus8.sum, bus8.cout);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1 0", bus8.in_ready, bus8.out_valid);
    end
    tick();
    bus8.in_valid = 1'b0;
    n_checks++;
    if (bus8.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_accept in_ready=%b required 0", bus8.in_ready);
    end
    collect8(0, s, c);
    n_checks++;
    if (s !== 8'h04 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_result sum=%h cout=%b required 04 0", s, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h10, 8'hF0, 8'hAA};
    logic [7:0] vb [3] = '{8'h20, 8'h20, 8'h55};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] ex [3] = '{9'h030, 9'h111, 9'h100};
    int idx = 0, got = 0, cyc = 0, last = 0;
    bit fin, fout;
    bus8.a = va[0]; bus8.b = vb[0]; bus8.cin = vc[0]; bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      fin  = bus8.in_valid && bus8.in_ready;
      fout = bus8.out_valid && bus8.out_ready;
      if (fout) begin
        n_checks++;
        if ({bus8.cout, bus8.sum} !== ex[got]) begin
          n_fail++;
          $display("FAIL b2b_result%0d got=%h required %h", got, {bus8.cout, bus8.sum}, ex[got]);
        end
        // Output handshake, IDLE accept edge, then WIDTH bit edges separate results.
        if (got > 0) begin
          n_checks++;
          if (cyc - last != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing%0d cycles=%0d required 10", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      tick(); cyc++;
      if (fin) begin
        idx++;
        if (idx < 3) begin bus8.a = va[idx]; bus8.b = vb[idx]; bus8.cin = vc[idx]; end
        else bus8.in_valid = 1'b0;
      end
    end
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b0;
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL b2b_count results=%0d required 3", got);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    logic [7:0] s; logic c;
    send8(8'h0F, 8'h01, 1'b0);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 00 0",
               bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus8.out_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midrun_no_valid pulses=%0d required 0", pulses);
    end
    send8(8'h3C, 8'h3C, 1'b1);
    collect8(0, s, c);
    n_checks++;
    if (s !== 8'h79 || c !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_next sum=%h cout=%b required 79 0", s, c);
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] a, b, s; logic c, ci;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      send8(a, b, ci);
      collect8(1, s, c);
      n_checks++;
      if ({c, s} !== ({1'b0, a} + {1'b0, b} + {8'h00, ci})) begin
        n_fail++;
        $display("FAIL rand8 a=%h b=%h cin=%b got=%h", a, b, ci, {c, s});
      end
    end
  endtask

  task automatic test_random_w2();
    logic [1:0] a, b; logic ci; logic [2:0] got;
    int t; bit done;
    for (int n = 0; n < 1000; n++) begin
      a = 2'($urandom); b = 2'($urandom); ci = 1'($urandom);
      bus2.a = a; bus2.b = b; bus2.cin = ci; bus2.in_valid = 1'b1;
      t = 0;
      while (!bus2.in_ready && t < 50) begin tick(); t++; end
      tick();
      bus2.in_valid = 1'b0; bus2.a = 2'($urandom);
      t = 0; done = 0; got = 'x;
      while (!done && t < 100) begin
        bus2.out_ready = 1'($urandom_range(0, 1));
        if (bus2.out_valid && bus2.out_ready) begin got = {bus2.cout, bus2.sum}; done = 1; end
        tick(); t++;
      end
      bus2.out_ready = 1'b0;
      n_checks++;
      if (got !== ({1'b0, a} + {1'b0, b} + {2'b00, ci})) begin
        n_fail++;
        $display("FAIL rand2 a=%h b=%h cin=%b got=%h", a, b, ci, got);
      end
    end
  endtask

  task automatic test_random_w32();
    logic [31:0] a, b; logic ci; logic [32:0] got;
    int t; bit done;
    for (int n = 0; n < 300; n++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom);
      if (n == 0) begin a = '1; b = '1; ci = 1'b1; end
      bus32.a = a; bus32.b = b; bus32.cin = ci; bus32.in_valid = 1'b1;
      t = 0;
      while (!bus32.in_ready && t < 100) begin tick(); t++; end
      tick();
      bus32.in_valid = 1'b0; bus32.b = $urandom;
      t = 0; done = 0; got = 'x;
      while (!done && t < 200) begin
        bus32.out_ready = 1'($urandom_range(0, 1));
        if (bus32.out_valid && bus32.out_ready) begin got = {bus32.cout, bus32.sum}; done = 1; end
        tick(); t++;
      end
      bus32.out_ready = 1'b0;
      n_checks++;
      if (got !== ({1'b0, a} + {1'b0, b} + {32'h0, ci})) begin
        n_fail++;
        $display("FAIL rand32 a=%h b=%h cin=%b got=%h", a, b, ci, got);
      end
    end
  endtask

  initial begin
    bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;  bus8.out_ready = 0;
    bus2.in_valid = 0;  bus2.a = 0;  bus2.b = 0;  bus2.cin = 0;  bus2.out_ready = 0;
    bus32.in_valid = 0; bus32.a = 0; bus32.b = 0; bus32.cin = 0; bus32.out_ready = 0;
    #2;
    test_reset();
    test_basic_latency();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random_w8();
    test_random_w2();
    test_random_w32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
